// File: rtl/ttc_trig_pkg.sv
// Shared definitions for the TTC trigger dispatcher: FSM encoding, async trigger type and
// the bit layout of the 128-bit trigger record.
package ttc_trig_pkg;

  localparam int unsigned IDLE  = 0;
  localparam int unsigned SEND  = 1;
  localparam int unsigned STORE = 2;
  localparam int unsigned ERROR = 3;

  typedef enum logic [3:0] {
    StIdle  = 4'(1 << IDLE),
    StSend  = 4'(1 << SEND),
    StStore = 4'(1 << STORE),
    StError = 4'(1 << ERROR)
  } state_e;

  localparam logic [4:0] ASYNC_TYPE = 5'b00111;

  localparam int unsigned REC_W      = 128;
  localparam int unsigned REC_TS_LSB = 0;

  // Record, LSB first: timestamp, trigger number, event count, type, empty flag, alarms.
  function automatic int unsigned rec_num_lsb(int unsigned ts_w);
    return ts_w;
  endfunction

  function automatic int unsigned rec_evt_lsb(int unsigned ts_w, int unsigned tnum_w);
    return ts_w + tnum_w;
  endfunction

  function automatic int unsigned rec_type_lsb(int unsigned ts_w, int unsigned tnum_w);
    return ts_w + 2 * tnum_w;
  endfunction

  function automatic int unsigned rec_empty_lsb(int unsigned ts_w, int unsigned tnum_w,
                                                int unsigned type_w);
    return ts_w + 2 * tnum_w + type_w;
  endfunction

  function automatic int unsigned rec_alarm_lsb(int unsigned ts_w, int unsigned tnum_w,
                                                int unsigned type_w);
    return ts_w + 2 * tnum_w + type_w + 1;
  endfunction

endpackage

// File: rtl/ttc_occupancy_tracker.sv
// One channel's DDR3 occupancy: saturating add/subtract register plus full and almost-full
// flags.
module ttc_occupancy_tracker #(
  parameter int unsigned OCC_W = 23
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_hold_zero,
  input  logic             i_add,
  input  logic             i_sub,
  input  logic [OCC_W-1:0] i_acq_size,
  input  logic [OCC_W-1:0] i_readout_size,
  input  logic [OCC_W-1:0] i_thres,
  output logic [OCC_W-1:0] o_occ,
  output logic             o_full,
  output logic             o_almost_full
);

  logic [OCC_W-1:0]        r_occ;
  logic signed [OCC_W+1:0] w_sum;
  logic [OCC_W-1:0]        w_next;
  logic [OCC_W:0]          w_free;

  always_comb begin
    w_sum = signed'({2'b00, r_occ});
    if (i_add) w_sum = w_sum + signed'({2'b00, i_acq_size});
    if (i_sub) w_sum = w_sum - signed'({2'b00, i_readout_size});
    // Sign bit means underflow; bit OCC_W on a non-negative sum means above capacity.
    if (w_sum[OCC_W+1])    w_next = '0;
    else if (w_sum[OCC_W]) w_next = '1;
    else                   w_next = w_sum[OCC_W-1:0];
  end

  assign w_free        = {1'b1, {OCC_W{1'b0}}} - {1'b0, r_occ};
  assign o_full        = i_en & (w_free < {1'b0, i_acq_size});
  assign o_almost_full = r_occ > i_thres;
  assign o_occ         = r_occ;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)          r_occ <= '0;
    else if (i_hold_zero) r_occ <= '0;
    else if (i_en)        r_occ <= w_next;
  end

endmodule

// File: rtl/ttc_trigger_dispatcher.sv
// TTC trigger dispatcher: numbers and timestamps triggers, gates them on type enables and
// DDR3 occupancy, forwards passed ones and emits one 128-bit record per accepted trigger.
module ttc_trigger_dispatcher
  import ttc_trig_pkg::*;
#(
  parameter int unsigned NCHAN  = 5,
  parameter int unsigned OCC_W  = 23,
  parameter int unsigned TNUM_W = 24,
  parameter int unsigned TS_W   = 44,
  parameter int unsigned TYPE_W = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_reset_trig_num,
  input  logic                   i_reset_trig_timestamp,
  input  logic                   i_clear_error,
  input  logic                   i_trigger,
  input  logic [TYPE_W-1:0]      i_trig_type,
  input  logic [2**TYPE_W-1:0]   i_trig_settings,
  input  logic                   i_async_mode,
  input  logic [3:0]             i_xadc_alarms,
  input  logic [NCHAN-1:0]       i_chan_en,
  input  logic [NCHAN*OCC_W-1:0] i_acq_size,
  input  logic                   i_readout_done,
  input  logic [NCHAN*OCC_W-1:0] i_readout_size,
  input  logic [OCC_W-1:0]       i_thres_overflow,
  input  logic                   i_acq_ready,
  output logic                   o_acq_trigger,
  output logic [TYPE_W-1:0]      o_acq_trig_type,
  output logic [TNUM_W-1:0]      o_acq_trig_num,
  input  logic                   i_fifo_ready,
  output logic                   o_fifo_valid,
  output logic [REC_W-1:0]       o_fifo_data,
  output logic [3:0]             o_state,
  output logic [TNUM_W-1:0]      o_trig_num,
  output logic [TS_W-1:0]        o_trig_timestamp,
  output logic [NCHAN*OCC_W-1:0] o_occupancy,
  output logic [31:0]            o_overflow_count,
  output logic [15:0]            o_busy_trig_count,
  output logic                   o_almost_full,
  output logic                   o_error_trig_rate
);

  localparam int unsigned NumLsb   = rec_num_lsb(TS_W);
  localparam int unsigned EvtLsb   = rec_evt_lsb(TS_W, TNUM_W);
  localparam int unsigned TypeLsb  = rec_type_lsb(TS_W, TNUM_W);
  localparam int unsigned EmptyLsb = rec_empty_lsb(TS_W, TNUM_W, TYPE_W);
  localparam int unsigned AlarmLsb = rec_alarm_lsb(TS_W, TNUM_W, TYPE_W);

  if (5 + TYPE_W + 2 * TNUM_W + TS_W > REC_W) begin : g_bad_widths
    $error("ttc_trigger_dispatcher: trigger record exceeds 128 bits");
  end

  state_e              r_state;
  logic [TS_W-1:0]     r_ts_cnt;
  logic [TS_W-1:0]     r_trig_timestamp;
  logic [TNUM_W-1:0]   r_trig_num;
  logic [TNUM_W-1:0]   r_acq_trig_num;
  logic [TNUM_W-1:0]   r_event_cnt;
  logic [TYPE_W-1:0]   r_acq_trig_type;
  logic [3:0]          r_alarms;
  logic                r_empty;
  logic                r_full_block;
  logic                r_acq_trigger;
  logic                r_fifo_valid;
  logic [REC_W-1:0]    r_fifo_data;
  logic [31:0]         r_overflow_count;
  logic [15:0]         r_busy_trig_count;
  logic [NCHAN-1:0]    w_full;
  logic [NCHAN-1:0]    w_almost_full;
  logic                w_ddr3_full;
  logic                w_empty_in;
  logic [REC_W-1:0]    w_record;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    ttc_occupancy_tracker #(
      .OCC_W(OCC_W)
    ) u_occ (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_en           (i_chan_en[i]),
      .i_hold_zero    (i_async_mode),
      .i_add          (r_acq_trigger & ~r_empty),
      .i_sub          (i_readout_done),
      .i_acq_size     (i_acq_size[i*OCC_W +: OCC_W]),
      .i_readout_size (i_readout_size[i*OCC_W +: OCC_W]),
      .i_thres        (i_thres_overflow),
      .o_occ          (o_occupancy[i*OCC_W +: OCC_W]),
      .o_full         (w_full[i]),
      .o_almost_full  (w_almost_full[i])
    );
  end

  assign w_ddr3_full = |w_full;
  assign w_empty_in  = i_async_mode ? (i_trig_type != TYPE_W'(ASYNC_TYPE))
                                    : (~i_trig_settings[i_trig_type] | w_ddr3_full);

  always_comb begin
    w_record                           = '0;
    w_record[REC_TS_LSB +: TS_W]       = r_trig_timestamp;
    w_record[NumLsb +: TNUM_W]         = r_acq_trig_num;
    w_record[EvtLsb +: TNUM_W]         = r_event_cnt;
    w_record[TypeLsb +: TYPE_W]        = r_acq_trig_type;
    w_record[EmptyLsb]                 = r_empty;
    w_record[AlarmLsb +: 4]            = r_alarms;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                     r_ts_cnt <= '0;
    else if (i_reset_trig_timestamp) r_ts_cnt <= '0;
    else                             r_ts_cnt <= r_ts_cnt + TS_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= StIdle;
      r_trig_timestamp  <= '0;
      r_trig_num        <= TNUM_W'(1);
      r_acq_trig_num    <= TNUM_W'(1);
      r_event_cnt       <= TNUM_W'(1);
      r_acq_trig_type   <= '0;
      r_alarms          <= '0;
      r_empty           <= 1'b0;
      r_full_block      <= 1'b0;
      r_acq_trigger     <= 1'b0;
      r_fifo_valid      <= 1'b0;
      r_fifo_data       <= '0;
      r_overflow_count  <= '0;
      r_busy_trig_count <= '0;
    end else begin
      r_acq_trigger <= 1'b0;
      if (i_trigger && r_state != StIdle && r_busy_trig_count != 16'hFFFF) begin
        r_busy_trig_count <= r_busy_trig_count + 16'd1;
      end
      unique case (r_state)
        StIdle: begin
          if (i_trigger) begin
            r_acq_trig_num   <= r_trig_num;
            r_trig_num       <= r_trig_num + TNUM_W'(1);
            r_acq_trig_type  <= i_trig_type;
            r_trig_timestamp <= r_ts_cnt;
            r_alarms         <= i_xadc_alarms;
            r_empty          <= w_empty_in;
            r_full_block     <= ~i_async_mode & i_trig_settings[i_trig_type] & w_ddr3_full;
            r_state          <= StSend;
          end
        end
        StSend: begin
          if (!i_acq_ready) begin
            r_state <= StError;
          end else begin
            if (!r_empty) begin
              r_acq_trigger <= 1'b1;
              r_event_cnt   <= r_event_cnt + TNUM_W'(1);
            end else if (r_full_block) begin
              r_overflow_count <= r_overflow_count + 32'd1;
            end
            // Record carries the event number assigned to this trigger, before the increment.
            r_fifo_data  <= w_record;
            r_fifo_valid <= 1'b1;
            r_state      <= StStore;
          end
        end
        StStore: begin
          if (r_fifo_valid && i_fifo_ready) begin
            r_fifo_valid <= 1'b0;
            r_empty      <= 1'b0;
            r_state      <= StIdle;
          end
        end
        StError: begin
          if (i_clear_error) begin
            r_busy_trig_count <= '0;
            r_empty           <= 1'b0;
            r_state           <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
      if (i_reset_trig_num) begin
        r_trig_num     <= TNUM_W'(1);
        r_acq_trig_num <= TNUM_W'(1);
        r_event_cnt    <= TNUM_W'(1);
      end
      if (i_reset_trig_timestamp) r_trig_timestamp <= '0;
    end
  end

  assign o_state           = r_state;
  assign o_acq_trigger     = r_acq_trigger;
  assign o_acq_trig_type   = r_acq_trig_type;
  assign o_acq_trig_num    = r_acq_trig_num;
  assign o_fifo_valid      = r_fifo_valid;
  assign o_fifo_data       = r_fifo_data;
  assign o_trig_num        = r_trig_num;
  assign o_trig_timestamp  = r_trig_timestamp;
  assign o_overflow_count  = r_overflow_count;
  assign o_busy_trig_count = r_busy_trig_count;
  assign o_almost_full     = |w_almost_full;
  assign o_error_trig_rate = (r_state == StError);

endmodule

// File: tb/tb_ttc_trigger_dispatcher.sv
// Self-checking bench for ttc_trigger_dispatcher: vector table, corner sequences and random
// triggers checked against a transaction-level model.
module tb_ttc_trigger_dispatcher;

  localparam int     NCHAN = 5;
  localparam int     OCC_W = 23;
  localparam int     OW    = NCHAN * OCC_W;
  localparam longint CAP   = 64'd1 << OCC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            reset_trig_num = 1'b0;
  logic            reset_trig_timestamp = 1'b0;
  logic            clear_error = 1'b0;
  logic            trigger = 1'b0;
  logic [4:0]      trig_type = '0;
  logic [31:0]     trig_settings = '0;
  logic            async_mode = 1'b0;
  logic [3:0]      xadc_alarms = '0;
  logic [4:0]      chan_en = '1;
  logic [OW-1:0]   acq_size = '0;
  logic            readout_done = 1'b0;
  logic [OW-1:0]   readout_size = '0;
  logic [22:0]     thres_overflow = 23'd1000;
  logic            acq_ready = 1'b1;
  logic            fifo_ready = 1'b1;
  logic            acq_trigger;
  logic [4:0]      acq_trig_type;
  logic [23:0]     acq_trig_num;
  logic            fifo_valid;
  logic [127:0]    fifo_data;
  logic [3:0]      state;
  logic [23:0]     trig_num;
  logic [43:0]     trig_timestamp;
  logic [OW-1:0]   occupancy;
  logic [31:0]     overflow_count;
  logic [15:0]     busy_trig_count;
  logic            almost_full;
  logic            error_trig_rate;

  ttc_trigger_dispatcher dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_reset_trig_num       (reset_trig_num),
    .i_reset_trig_timestamp (reset_trig_timestamp),
    .i_clear_error          (clear_error),
    .i_trigger              (trigger),
    .i_trig_type            (trig_type),
    .i_trig_settings        (trig_settings),
    .i_async_mode           (async_mode),
    .i_xadc_alarms          (xadc_alarms),
    .i_chan_en              (chan_en),
    .i_acq_size             (acq_size),
    .i_readout_done         (readout_done),
    .i_readout_size         (readout_size),
    .i_thres_overflow       (thres_overflow),
    .i_acq_ready            (acq_ready),
    .o_acq_trigger          (acq_trigger),
    .o_acq_trig_type        (acq_trig_type),
    .o_acq_trig_num         (acq_trig_num),
    .i_fifo_ready           (fifo_ready),
    .o_fifo_valid           (fifo_valid),
    .o_fifo_data            (fifo_data),
    .o_state                (state),
    .o_trig_num             (trig_num),
    .o_trig_timestamp       (trig_timestamp),
    .o_occupancy            (occupancy),
    .o_overflow_count       (overflow_count),
    .o_busy_trig_count      (busy_trig_count),
    .o_almost_full          (almost_full),
    .o_error_trig_rate      (error_trig_rate)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      m_occ[NCHAN];
  longint      m_num = 1;
  longint      m_evt = 1;
  longint      m_ovf = 0;
  longint      m_busy = 0;
  longint      t0 = 0;

  typedef struct {
    logic [4:0] ty;
    logic       en;
    logic       async_m;
    logic       exp_empty;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v < 0) return 0;
    if (v > CAP - 1) return CAP - 1;
    return v;
  endfunction

  function automatic logic [OW-1:0] model_occ();
    logic [OW-1:0] r;
    for (int i = 0; i < NCHAN; i++) r[i*OCC_W +: OCC_W] = m_occ[i][22:0];
    return r;
  endfunction

  function automatic logic model_almost();
    logic a;
    a = 1'b0;
    for (int i = 0; i < NCHAN; i++) if (m_occ[i] > longint'(thres_overflow)) a = 1'b1;
    return a;
  endfunction

  task automatic idle_readout(input logic [OW-1:0] rs);
    readout_size = rs;
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (async_mode) m_occ[i] = 0;
      else if (chan_en[i]) m_occ[i] = clamp(m_occ[i] - longint'(rs[i*OCC_W +: OCC_W]));
    end
    chk("occ_after_readout", occupancy, model_occ());
  endtask

  // One full trigger transaction from IDLE back to IDLE, with optional FIFO stall.
  task automatic run_trig(input logic [4:0] ty, input logic en_bit, input logic async_m,
                          input logic rd, input int stall, input int extra,
                          output logic got_empty);
    logic         full, exp_e;
    logic [3:0]   al;
    logic [127:0] rec;
    longint       te, old_num;
    int           nb;
    al = 4'($urandom);
    xadc_alarms = al;
    trig_settings = $urandom;
    trig_settings[ty] = en_bit;
    async_mode = async_m;
    full = 1'b0;
    for (int i = 0; i < NCHAN; i++)
      if (chan_en[i] && (CAP - m_occ[i]) < longint'(acq_size[i*OCC_W +: OCC_W])) full = 1'b1;
    exp_e = async_m ? (ty != 5'd7) : (!en_bit || full);
    old_num = m_num;
    trig_type = ty;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    te = $time - 1;
    chk("state_send", 128'(state), 128'(4'b0010));
    tick();
    rec = '0;
    rec[43:0]   = 44'((te - t0) / 10 - 1);
    rec[67:44]  = m_num[23:0];
    rec[91:68]  = m_evt[23:0];
    rec[96:92]  = ty;
    rec[97]     = exp_e;
    rec[101:98] = al;
    chk("acq_trigger", 128'(acq_trigger), 128'(!exp_e));
    chk("fifo_valid", 128'(fifo_valid), 128'(1'b1));
    chk("fifo_data", fifo_data, rec);
    chk("acq_trig_type", 128'(acq_trig_type), 128'(ty));
    got_empty = fifo_data[97];
    readout_done = rd;
    nb = 0;
    if (stall > 0) begin
      fifo_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        trigger = (k % 4 == 0) && (k / 4 < extra);
        if (trigger) nb++;
        tick();
        trigger = 1'b0;
        readout_done = 1'b0;
        chk("stall_valid", 128'(fifo_valid), 128'(1'b1));
        chk("stall_data", fifo_data, rec);
        chk("stall_acq_trigger", 128'(acq_trigger), 128'(1'b0));
      end
      fifo_ready = 1'b1;
    end
    tick();
    readout_done = 1'b0;
    chk("state_idle", 128'(state), 128'(4'b0001));
    chk("valid_dropped", 128'(fifo_valid), 128'(1'b0));
    for (int i = 0; i < NCHAN; i++) begin
      if (async_m) m_occ[i] = 0;
      else if (chan_en[i])
        m_occ[i] = clamp(m_occ[i] + (exp_e ? 0 : longint'(acq_size[i*OCC_W +: OCC_W]))
                         - (rd ? longint'(readout_size[i*OCC_W +: OCC_W]) : 0));
    end
    if (!async_m && en_bit && full) m_ovf++;
    m_num = (m_num + 1) % (64'd1 << 24);
    if (!exp_e) m_evt++;
    m_busy = m_busy + nb;
    chk("occupancy", 128'(occupancy), 128'(model_occ()));
    chk("almost_full", 128'(almost_full), 128'(model_almost()));
    chk("trig_num", 128'(trig_num), 128'(m_num[23:0]));
    chk("acq_trig_num", 128'(acq_trig_num), 128'(old_num[23:0]));
    chk("overflow_count", 128'(overflow_count), 128'(m_ovf[31:0]));
    chk("busy_trig_count", 128'(busy_trig_count), 128'(m_busy[15:0]));
  endtask

  initial begin
    logic       e;
    logic [4:0] ty;
    for (int i = 0; i < NCHAN; i++) m_occ[i] = 0;
    tbl[0] = '{5'd1,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{5'd2,  1'b0, 1'b0, 1'b1};
    tbl[2] = '{5'd7,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{5'd3,  1'b1, 1'b1, 1'b1};
    tbl[4] = '{5'd7,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{5'd31, 1'b1, 1'b0, 1'b0};

    repeat (3) tick();
    chk("rst_state", 128'(state), 128'(4'b0001));
    chk("rst_trig_num", 128'(trig_num), 128'(24'd1));
    chk("rst_acq_trig_num", 128'(acq_trig_num), 128'(24'd1));
    chk("rst_fifo_valid", 128'(fifo_valid), 128'(1'b0));
    chk("rst_acq_trigger", 128'(acq_trigger), 128'(1'b0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_counters", 128'({overflow_count, busy_trig_count}), 128'(0));
    chk("rst_error", 128'({error_trig_rate, almost_full}), 128'(0));
    reset = 1'b0;
    tick();
    reset_trig_timestamp = 1'b1;
    tick();
    reset_trig_timestamp = 1'b0;
    t0 = $time - 1;
    repeat (3) tick();

    // Vector table: gating decision by type enable and mode, small sizes on all channels.
    for (int i = 0; i < NCHAN; i++) acq_size[i*OCC_W +: OCC_W] = 23'(100 + i);
    for (int v = 0; v < 6; v++) begin
      run_trig(tbl[v].ty, tbl[v].en, tbl[v].async_m, 1'b0, 0, 0, e);
      chk("table_empty", 128'(e), 128'(tbl[v].exp_empty));
    end
    chk("table_no_overflow", 128'(overflow_count), 128'(0));

    // DDR3 full: occupancy three below capacity, request four.
    chan_en = 5'b00001;
    idle_readout('1);
    acq_size = '0;
    acq_size[22:0] = 23'(1 << 22);
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 0, 0, e);
    acq_size[22:0] = 23'((1 << 22) - 3);
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 0, 0, e);
    acq_size[22:0] = 23'd4;
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 0, 0, e);
    chk("full_empty", 128'(e), 128'(1'b1));
    chk("full_overflow", 128'(overflow_count), 128'(1));
    chk("full_occ0", 128'(occupancy[22:0]), 128'(23'h7FFFFD));
    chk("full_almost", 128'(almost_full), 128'(1'b1));

    // Add and subtract in the same cycle, clamped at zero.
    idle_readout('1);
    acq_size[22:0] = 23'd5;
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 0, 0, e);
    acq_size[22:0] = 23'd2;
    readout_size = '0;
    readout_size[22:0] = 23'd9;
    run_trig(5'd1, 1'b1, 1'b0, 1'b1, 0, 0, e);
    chk("clamp_occ0", 128'(occupancy[22:0]), 128'(0));

    // FIFO back-pressure with extra triggers arriving while busy.
    chan_en = '1;
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 20, 4, e);
    chk("busy_count4", 128'(busy_trig_count), 128'(16'd4));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("clear_ignored_idle", 128'(busy_trig_count), 128'(16'd4));

    // Acquisition not ready: ERROR until cleared.
    acq_ready = 1'b0;
    trig_settings[1] = 1'b1;
    trig_type = 5'd1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    m_num++;
    tick();
    chk("err_state", 128'(state), 128'(4'b1000));
    chk("err_flag", 128'(error_trig_rate), 128'(1'b1));
    chk("err_no_record", 128'({fifo_valid, acq_trigger}), 128'(0));
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (2) tick();
    chk("err_busy", 128'(busy_trig_count), 128'(16'd5));
    chk("err_hold", 128'(state), 128'(4'b1000));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    acq_ready = 1'b1;
    m_busy = 0;
    chk("clr_state", 128'(state), 128'(4'b0001));
    chk("clr_busy", 128'(busy_trig_count), 128'(0));
    chk("clr_flag", 128'(error_trig_rate), 128'(1'b0));
    chk("err_trig_num", 128'(trig_num), 128'(m_num[23:0]));

    // Trigger-number reset restarts numbering and event count at 1.
    reset_trig_num = 1'b1;
    tick();
    reset_trig_num = 1'b0;
    m_num = 1;
    m_evt = 1;
    chk("rtn_trig_num", 128'(trig_num), 128'(24'd1));
    run_trig(5'd1, 1'b1, 1'b0, 1'b0, 0, 0, e);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      chan_en = 5'($urandom);
      for (int i = 0; i < NCHAN; i++) begin
        acq_size[i*OCC_W +: OCC_W]     = 23'($urandom_range(0, 1 << 22));
        readout_size[i*OCC_W +: OCC_W] = 23'($urandom_range(0, 1 << 22));
      end
      case ($urandom % 4)
        0: ty = 5'd1;
        1: ty = 5'd2;
        2: ty = 5'd7;
        default: ty = 5'($urandom);
      endcase
      run_trig(ty, 1'($urandom), ($urandom % 5) == 0, 1'($urandom), 0, 0, e);
      if ($urandom % 3 == 0) begin
        for (int i = 0; i < NCHAN; i++)
          readout_size[i*OCC_W +: OCC_W] = 23'($urandom_range(0, 1 << 22));
        idle_readout(readout_size);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ttc_trigger_dispatcher.md
Name: ttc_trigger_dispatcher

Overview:
Parametrised successor of the TTC trigger FSM. It accepts TTC triggers on the 40 MHz clock, stamps each with a number and timestamp, and gates it against per-type enables and per-channel DDR3 occupancy. Passed triggers are forwarded to the channel acquisition controller, and one 128-bit trigger record is pushed to the TTC Trigger FIFO for every trigger. New versus the previous generation: NCHAN channels, saturating occupancy arithmetic, counting of busy-time triggers, and an ERROR state that software can clear.

Parameters:
NCHAN, 5, number of digitizer channels
OCC_W, 23, occupancy/size width; channel capacity = 2^OCC_W bursts
TNUM_W, 24, trigger and event number width
TS_W, 44, timestamp width
TYPE_W, 5, trigger type width

Ports:
clk  in  1  40 MHz TTC clock
reset  in  1  asynchronous, active-high
reset_trig_num  in  1  sync; trig_num, acq_trig_num, event count -> 1
reset_trig_timestamp  in  1  sync; timestamp counter and trig_timestamp -> 0
clear_error  in  1  sync pulse; ERROR -> IDLE, zero busy_trig_count
trigger  in  1  TTC trigger strobe
trig_type  in  TYPE_W  trigger type
trig_settings  in  2^TYPE_W  per-type enable
async_mode  in  1  async readout mode
xadc_alarms  in  4  alarm snapshot
chan_en  in  NCHAN  enabled channels
acq_size  in  NCHAN*OCC_W  bursts added per accepted trigger, channel i at [i*OCC_W +: OCC_W]
readout_done  in  1  readout completed
readout_size  in  NCHAN*OCC_W  bursts freed per readout
thres_overflow  in  OCC_W  almost-full threshold
acq_ready  in  1  channels ready
acq_trigger  out  1  one-cycle trigger to acquisition controller
acq_trig_type  out  TYPE_W  latched type
acq_trig_num  out  TNUM_W  latched trigger number
fifo_ready  in  1  FIFO ready
fifo_valid  out  1  record valid
fifo_data  out  128  trigger record
state  out  4  one-hot FSM state
trig_num  out  TNUM_W  next trigger number
trig_timestamp  out  TS_W  latched timestamp
occupancy  out  NCHAN*OCC_W  stored bursts per channel
overflow_count  out  32  triggers blocked by DDR3 full
busy_trig_count  out  16  triggers received outside IDLE, saturating
almost_full  out  1  OR over channels of occ > thres_overflow
error_trig_rate  out  1  state==ERROR

Behaviour:
- Reset values: state IDLE (4'b0001). trig_num, acq_trig_num and event count = 1. All other outputs and registers = 0.
- Timestamp counter increments every cycle and wraps modulo 2^TS_W.
- full_i = chan_en[i] & ((2^OCC_W - occ_i) < acq_size_i), computed at OCC_W+1 bits. ddr3_full = OR of full_i.
- IDLE + trigger at cycle T, all latched at T+1:
  - acq_trig_num = trig_num; trig_num increments, wrapping.
  - acq_trig_type, trig_timestamp and alarms are latched.
  - empty = sync ? (~trig_settings[trig_type] | ddr3_full) : (trig_type != ASYNC_TYPE).
  - state goes to SEND.
- SEND:
  - ~acq_ready -> ERROR.
  - Otherwise, if not empty: acq_trigger is high at T+2 for exactly 1 cycle, and the event count increments.
  - Otherwise, if the trigger was blocked only by ddr3_full (sync mode, type enabled): overflow_count increments.
  - Then state goes to STORE.
- STORE:
  - fifo_valid is high from state entry. fifo_data = {pad0, alarms[3:0], empty, type, event_cnt, acq_trig_num, trig_timestamp}, stable while valid.
  - On valid & ready: the next cycle is IDLE with fifo_valid=0 and empty cleared.
  - Minimum trigger-to-trigger spacing is therefore 3 cycles.
- ERROR: stays until clear_error; clear_error is ignored in other states.
- Trigger while not in IDLE: dropped (no record, no number consumed). busy_trig_count increments, saturating at 16'hFFFF.
- Occupancy, per channel, when chan_en[i]:
  - occ_next = occ + (acq_trigger & ~empty ? acq_size_i : 0) - (readout_done ? readout_size_i : 0).
  - Computed at OCC_W+2 bits signed, clamped to [0, 2^OCC_W - 1]. Simultaneous add and subtract in one cycle is legal.
- async_mode high: all occupancies are held at 0.
- reset_trig_num / reset_trig_timestamp take priority over the same-cycle increment.
- Elaboration error if 5+TYPE_W+2*TNUM_W+TS_W > 128.

Decomposition:
- Package ttc_trig_pkg holds:
  - state bit indices IDLE=0, SEND=1, STORE=2, ERROR=3;
  - ASYNC_TYPE = 5'b00111;
  - the FIFO record field offsets.
- One sub-module, ttc_occupancy_tracker, instantiated NCHAN times. It holds one channel's saturating occupancy register and produces that channel's full and almost-full flags.

Test Plan:
1. Sync mode, trig_settings[1]=1, type 1 trigger at cycle 10 with fifo_ready=1 -> acq_trigger at cycle 12; record {empty=0, trig_num=1, event=1}; trig_num=2; occ0 += acq_size0.
2. Type 2 with trig_settings[2]=0 -> no acq_trigger; record empty=1; overflow_count stays 0.
3. occ0=2^23-3, acq_size0=4 -> empty=1, overflow_count=1, occ0 unchanged.
4. occ0=5, readout_size0=9, readout_done together with acq_trigger (acq_size0=2) -> occ0=0 (clamped).
5. fifo_ready held low 20 cycles, extra triggers during that time -> valid held, data stable; busy_trig_count=number of extra triggers; trig_num unchanged by them.
6. acq_ready=0 at SEND -> error_trig_rate=1; clear_error -> IDLE next cycle, busy_trig_count=0.
